coverfloat_vector_loader: RTL and testbench

//  Producer end of coverfloat_interface. Parses a framed 32-bit word stream of covervectors
//  (from a test-vector memory or host FIFO) into the interface fields op/rm/a/b/c/operandFmt/

---
 rtl/coverfloat_vector_loader.sv | 136 +++++++++++++
 tb/tb_coverfloat_vector_loader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coverfloat_vector_loader.sv
// Producer end of the coverfloat interface: frames a 32-bit word stream of
// covervectors behind a sync word, unpacks it into the interface fields and
// hands the finished vector to the coverage sampler over valid/ready.
module coverfloat_vector_loader #(
    parameter logic [31:0] SYNC_WORD = 32'hCF10_A7ED,
    parameter int          ERR_W     = 16,
    parameter int          CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_abort,
    output logic               vec_valid,
    input  logic               vec_ready,
    output logic [31:0]        op,
    output logic [7:0]         rm,
    output logic [7:0]         operandFmt,
    output logic [7:0]         resultFmt,
    output logic [7:0]         exceptionBits,
    output logic [127:0]       a,
    output logic [127:0]       b,
    output logic [127:0]       c,
    output logic [127:0]       result,
    output logic               intermS,
    output logic [31:0]        intermX,
    output logic [191:0]       intermM,
    output logic [ERR_W-1:0]   hdr_err_cnt,
    output logic [CNT_W-1:0]   vec_cnt,
    output logic               frame_err
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'd25;

    state_t     state;
    state_t     stateNext;
    logic [4:0] idx;
    logic       accept;
    logic [6:0] laneOff;
    logic [7:0] mOff;

    // Words are taken only in HUNT/LOAD, never while reset or abort is high.
    assign in_ready  = !rst && !in_abort && (state == HUNT || state == LOAD);
    assign accept    = in_valid && in_ready;
    assign vec_valid = (state == HOLD);

    // Bit offsets of the current word inside the 128-bit operands and intermM.
    // Operand groups start at idx 2, 6, 10, 14, so idx[1:0]+2 is the lane.
    always_comb begin
        laneOff = {idx[1:0] + 2'd2, 5'b0};
        mOff    = ({3'b000, idx} - 8'd20) << 5;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) state <= HUNT;
        else     state <= stateNext;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case leaves stateNext
        // unassigned, which would infer a latch.
        stateNext = state;
        case (state)
            HUNT: if (accept && in_data == SYNC_WORD) stateNext = LOAD;
            LOAD: begin
                if (in_abort)                     stateNext = HUNT;
                else if (accept && idx == LAST_IDX) stateNext = HOLD;
            end
            HOLD: if (vec_ready) stateNext = HUNT;
            default: stateNext = HUNT;
        endcase
    end

    // Word index, field unpacking, counters and the sticky framing error.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the field registers are plain flops, not a memory, and the
            // outputs must read zero after reset, so they are reset explicitly.
            idx           <= '0;
            op            <= '0;
            rm            <= '0;
            operandFmt    <= '0;
            resultFmt     <= '0;
            exceptionBits <= '0;
            a             <= '0;
            b             <= '0;
            c             <= '0;
            result        <= '0;
            intermS       <= 1'b0;
            intermX       <= '0;
            intermM       <= '0;
            hdr_err_cnt   <= '0;
            vec_cnt       <= '0;
            frame_err     <= 1'b0;
        end else begin
            if (state == HUNT && accept) begin
                if (in_data == SYNC_WORD)  idx <= '0;
                else if (hdr_err_cnt != '1) hdr_err_cnt <= hdr_err_cnt + ERR_W'(1);
            end

            if (state == LOAD && accept) begin
                idx <= idx + 5'd1;
                case (idx)
                    5'd0:  op <= in_data;
                    5'd1:  {rm, operandFmt, resultFmt, exceptionBits} <= in_data;
                    5'd2, 5'd3, 5'd4, 5'd5:     a[laneOff +: 32]      <= in_data;
                    5'd6, 5'd7, 5'd8, 5'd9:     b[laneOff +: 32]      <= in_data;
                    5'd10, 5'd11, 5'd12, 5'd13: c[laneOff +: 32]      <= in_data;
                    5'd14, 5'd15, 5'd16, 5'd17: result[laneOff +: 32] <= in_data;
                    5'd18: intermX <= in_data;
                    5'd19: begin
                        intermS <= in_data[0];
                        if (in_data[31:1] != '0) frame_err <= 1'b1;
                    end
                    5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25:
                        intermM[mOff +: 32] <= in_data;
                    default: ;
                endcase
            end

            if (state == HOLD && vec_ready) vec_cnt <= vec_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_coverfloat_vector_loader.sv
// Directed bench for coverfloat_vector_loader: frames are built from a vector
// record, streamed in, and the unpacked fields compared against that record.
module tb_coverfloat_vector_loader;

    localparam logic [31:0] SYNC = 32'hCF10_A7ED;

    typedef struct {
        logic [31:0]  op;
        logic [7:0]   rm;
        logic [7:0]   operandFmt;
        logic [7:0]   resultFmt;
        logic [7:0]   exceptionBits;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        logic [127:0] result;
        logic         intermS;
        logic [31:0]  intermX;
        logic [191:0] intermM;
    } vec_t;

    typedef logic [31:0] frame_t [27];

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_abort;
    logic         vec_valid;
    logic         vec_ready;
    logic [31:0]  op;
    logic [7:0]   rm;
    logic [7:0]   operandFmt;
    logic [7:0]   resultFmt;
    logic [7:0]   exceptionBits;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] c;
    logic [127:0] result;
    logic         intermS;
    logic [31:0]  intermX;
    logic [191:0] intermM;
    logic [15:0]  hdr_err_cnt;
    logic [31:0]  vec_cnt;
    logic         frame_err;

    int total = 0;
    int bad   = 0;
    int expCnt = 0;

    coverfloat_vector_loader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_abort(in_abort),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .op(op), .rm(rm), .operandFmt(operandFmt), .resultFmt(resultFmt),
        .exceptionBits(exceptionBits), .a(a), .b(b), .c(c), .result(result),
        .intermS(intermS), .intermX(intermX), .intermM(intermM),
        .hdr_err_cnt(hdr_err_cnt), .vec_cnt(vec_cnt), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Frame layout: sync, op, {rm,opFmt,resFmt,exc}, a/b/c/result low word
    // first, intermX, {31'b0,intermS}, intermM low word first.
    function automatic frame_t toWords(input vec_t v);
        frame_t w;
        w[0] = SYNC;
        w[1] = v.op;
        w[2] = {v.rm, v.operandFmt, v.resultFmt, v.exceptionBits};
        for (int k = 0; k < 4; k++) begin
            w[3 + k]  = v.a[32*k +: 32];
            w[7 + k]  = v.b[32*k +: 32];
            w[11 + k] = v.c[32*k +: 32];
            w[15 + k] = v.result[32*k +: 32];
        end
        w[19] = v.intermX;
        w[20] = {31'b0, v.intermS};
        for (int k = 0; k < 6; k++) w[21 + k] = v.intermM[32*k +: 32];
        return w;
    endfunction

    function automatic logic [31:0] mix(input int s, input int k);
        return (32'(s) * 32'h9E37_79B9) ^ (32'(k) * 32'h0100_0193) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t seedVec(input int s);
        vec_t v;
        v.op = mix(s, 0);
        {v.rm, v.operandFmt, v.resultFmt, v.exceptionBits} = mix(s, 1);
        v.a      = {mix(s, 5),  mix(s, 4),  mix(s, 3),  mix(s, 2)};
        v.b      = {mix(s, 9),  mix(s, 8),  mix(s, 7),  mix(s, 6)};
        v.c      = {mix(s, 13), mix(s, 12), mix(s, 11), mix(s, 10)};
        v.result = {mix(s, 17), mix(s, 16), mix(s, 15), mix(s, 14)};
        v.intermX = mix(s, 18);
        v.intermS = s[0];
        v.intermM = {mix(s, 25), mix(s, 24), mix(s, 23), mix(s, 22), mix(s, 21), mix(s, 20)};
        return v;
    endfunction

    function automatic bit fieldsOk(input vec_t v);
        return op === v.op && rm === v.rm && operandFmt === v.operandFmt &&
               resultFmt === v.resultFmt && exceptionBits === v.exceptionBits &&
               a === v.a && b === v.b && c === v.c && result === v.result &&
               intermS === v.intermS && intermX === v.intermX && intermM === v.intermM;
    endfunction

    // Present one word and hold it until accepted (bounded).
    task automatic sendWord(input logic [31:0] w, input bit gaps);
        int n = 0;
        if (gaps && $urandom_range(1) == 1) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        #1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input frame_t w, input bit gaps);
        for (int i = 0; i < 27; i++) sendWord(w[i], gaps);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_abort = 1'b0; vec_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (vec_valid !== 1'b0 || vec_cnt !== 32'd0 || hdr_err_cnt !== 16'd0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: vec_valid=%b vec_cnt=%0d hdr=%0d frame_err=%b required 0/0/0/0",
                     vec_valid, vec_cnt, hdr_err_cnt, frame_err);
        end
        total++;
        if (op !== '0 || a !== '0 || result !== '0 || intermM !== '0 || intermS !== 1'b0 || rm !== '0) begin
            bad++; $display("FAIL reset_fields: op=%h a=%h required all zero", op, a);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_hunt_ready: got %b required 1", in_ready);
        end
        expCnt = 0;
    endtask

    task automatic test_basic;
        vec_t v;
        v.op = 32'h0000_0001;
        {v.rm, v.operandFmt, v.resultFmt, v.exceptionBits} = 32'h0302_0100;
        v.a       = 128'h3F80_0000;
        v.b       = {32'd9, 32'd8, 32'd7, 32'd6};
        v.c       = {32'd13, 32'd12, 32'd11, 32'd10};
        v.result  = {32'd17, 32'd16, 32'd15, 32'd14};
        v.intermX = 32'd18;
        v.intermS = 1'b1;
        v.intermM = {32'd25, 32'd24, 32'd23, 32'd22, 32'd21, 32'd20};
        sendFrame(toWords(v), 1'b0);
        @(negedge clk);
        total++;
        if (vec_valid !== 1'b1 || !fieldsOk(v)) begin
            bad++;
            $display("FAIL basic_vector: vec_valid=%b op=%h a=%h intermM=%h required 1 %h %h %h",
                     vec_valid, op, a, intermM, v.op, v.a, v.intermM);
        end
        total++;
        if (rm !== 8'h03 || operandFmt !== 8'h02 || resultFmt !== 8'h01 || exceptionBits !== 8'h00) begin
            bad++;
            $display("FAIL basic_fmt: rm=%h opFmt=%h resFmt=%h exc=%h required 03 02 01 00",
                     rm, operandFmt, resultFmt, exceptionBits);
        end
        expCnt++;
        @(negedge clk);
        total++;
        if (vec_valid !== 1'b0 || vec_cnt !== 32'd1) begin
            bad++;
            $display("FAIL basic_handoff: vec_valid=%b vec_cnt=%0d required 0 1", vec_valid, vec_cnt);
        end
    endtask

    task automatic test_hunt;
        vec_t v = seedVec(7);
        sendWord(32'h0000_0000, 1'b0);
        sendWord(32'h1234_5678, 1'b0);
        sendWord(SYNC ^ 32'h1, 1'b0);
        @(negedge clk);
        total++;
        if (hdr_err_cnt !== 16'd3) begin
            bad++; $display("FAIL hunt_count: got %0d required 3", hdr_err_cnt);
        end
        sendFrame(toWords(v), 1'b0);
        @(negedge clk);
        total++;
        if (vec_valid !== 1'b1 || !fieldsOk(v)) begin
            bad++;
            $display("FAIL hunt_vector: vec_valid=%b op=%h a=%h required 1 %h %h", vec_valid, op, a, v.op, v.a);
        end
        expCnt++;
        @(negedge clk);
        total++;
        if (vec_cnt !== 32'(expCnt) || hdr_err_cnt !== 16'd3) begin
            bad++;
            $display("FAIL hunt_after: vec_cnt=%0d hdr=%0d required %0d 3", vec_cnt, hdr_err_cnt, expCnt);
        end
        force dut.hdr_err_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.hdr_err_cnt;
        sendWord(32'hDEAD_BEEF, 1'b0);
        sendWord(32'h0BAD_F00D, 1'b0);
        @(negedge clk);
        total++;
        if (hdr_err_cnt !== 16'hFFFF) begin
            bad++; $display("FAIL hunt_saturate: got %h required ffff", hdr_err_cnt);
        end
    endtask

    task automatic test_stall;
        vec_t v = seedVec(11);
        int badCycles = 0;
        vec_ready = 1'b0;
        sendFrame(toWords(v), 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_abort = (i >= 5);
            in_valid = (i >= 5);
            in_data  = SYNC;
            #1;
            if (vec_valid !== 1'b1 || in_ready !== 1'b0 || !fieldsOk(v)) badCycles++;
        end
        total++;
        if (badCycles != 0) begin
            bad++;
            $display("FAIL stall_hold: %0d bad cycles (vec_valid=%b in_ready=%b) required 0",
                     badCycles, vec_valid, in_ready);
        end
        @(negedge clk);
        in_abort = 1'b0; in_valid = 1'b0; vec_ready = 1'b1;
        expCnt++;
        @(negedge clk);
        total++;
        if (vec_valid !== 1'b0 || vec_cnt !== 32'(expCnt) || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: vec_valid=%b vec_cnt=%0d in_ready=%b required 0 %0d 1",
                     vec_valid, vec_cnt, in_ready, expCnt);
        end
    endtask

    task automatic test_abort;
        frame_t wOld = toWords(seedVec(21));
        vec_t   v    = seedVec(22);
        for (int i = 0; i < 13; i++) sendWord(wOld[i], 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_abort = 1'b1; in_data = wOld[13];
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL abort_ready: got %b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        in_abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (vec_valid !== 1'b0) begin
            bad++; $display("FAIL abort_valid: got %b required 0", vec_valid);
        end
        sendFrame(toWords(v), 1'b0);
        @(negedge clk);
        total++;
        if (vec_valid !== 1'b1 || !fieldsOk(v)) begin
            bad++;
            $display("FAIL abort_vector: vec_valid=%b op=%h a=%h required 1 %h %h", vec_valid, op, a, v.op, v.a);
        end
        expCnt++;
        @(negedge clk);
        total++;
        if (vec_cnt !== 32'(expCnt)) begin
            bad++; $display("FAIL abort_count: got %0d required %0d", vec_cnt, expCnt);
        end
    endtask

    task automatic test_frame_err;
        vec_t   v  = seedVec(30);
        vec_t   v2 = seedVec(31);
        frame_t w  = toWords(v);
        w[20] = 32'h0000_0003;
        v.intermS = 1'b1;
        sendFrame(w, 1'b0);
        @(negedge clk);
        total++;
        if (vec_valid !== 1'b1 || !fieldsOk(v) || frame_err !== 1'b1) begin
            bad++;
            $display("FAIL ferr_set: vec_valid=%b intermS=%b frame_err=%b required 1 1 1",
                     vec_valid, intermS, frame_err);
        end
        expCnt++;
        sendFrame(toWords(v2), 1'b0);
        @(negedge clk);
        total++;
        if (vec_valid !== 1'b1 || !fieldsOk(v2) || frame_err !== 1'b1) begin
            bad++;
            $display("FAIL ferr_sticky: vec_valid=%b op=%h frame_err=%b required 1 %h 1",
                     vec_valid, op, frame_err, v2.op);
        end
        expCnt++;
    endtask

    task automatic test_back_to_back;
        int badFrames = 0;
        int leaks = 0;
        for (int f = 0; f < 100; f++) begin
            vec_t v = seedVec(f + 100);
            if (f == 50) begin
                frame_t wCut = toWords(seedVec(999));
                for (int i = 0; i < 11; i++) sendWord(wCut[i], 1'b1);
                @(negedge clk);
                rst = 1'b1;
                #1;
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL b2b_rst_ready: got %b required 0", in_ready);
                end
                @(negedge clk);
                rst = 1'b0;
                #1;
                total++;
                if (vec_cnt !== 32'd0 || op !== 32'd0 || frame_err !== 1'b0 || hdr_err_cnt !== 16'd0) begin
                    bad++;
                    $display("FAIL b2b_rst_state: vec_cnt=%0d op=%h frame_err=%b hdr=%0d required 0 0 0 0",
                             vec_cnt, op, frame_err, hdr_err_cnt);
                end
                expCnt = 0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    if (vec_valid !== 1'b0) leaks++;
                end
                total++;
                if (leaks != 0) begin
                    bad++; $display("FAIL b2b_cut_frame: vec_valid high %0d cycles required 0", leaks);
                end
            end
            sendFrame(toWords(v), 1'b1);
            @(negedge clk);
            if (vec_valid !== 1'b1 || !fieldsOk(v)) begin
                badFrames++;
                $display("FAIL b2b_frame_%0d: vec_valid=%b op=%h a=%h required 1 %h %h",
                         f, vec_valid, op, a, v.op, v.a);
            end
            expCnt++;
        end
        total++;
        if (badFrames != 0) begin
            bad++; $display("FAIL b2b_frames: %0d bad frames required 0", badFrames);
        end
        @(negedge clk);
        total++;
        if (vec_cnt !== 32'(expCnt)) begin
            bad++; $display("FAIL b2b_count: got %0d required %0d", vec_cnt, expCnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hunt();
        test_stall();
        test_abort();
        test_frame_err();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
